// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Holds the owner state encoding and the one-hot grant values decoded from it.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // One-hot {m1,m0} owner view of a state; anything unexpected reads as idle.
    function automatic logic [1:0] grant_of(state_t s);
        case (s)
            OWN0:    return GRANT_M0;
            OWN1:    return GRANT_M1;
            default: return GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// One request/response bus port: a requester drives valid/write_enable/address/write_data,
// a responder returns read_data/ready. Used for both master ports and the slave port.
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  valid;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  ready;

    modport master (
        output valid,
        output write_enable,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  valid,
        input  write_enable,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );

endinterface

// File: rtl/bus_arbiter_mux.sv
// Combinational routing between the two master ports and the single slave port.
// The owner selected by grant sees the slave; the non-owner sees ready=0 and read data 0.
module bus_arbiter_mux
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]    grant,
    bus_arbiter_if.slave  m0,
    bus_arbiter_if.slave  m1,
    bus_arbiter_if.master slv
);

    // Forward the owner's request to the slave and return the response only to the owner.
    always_comb begin
        slv.valid        = 1'b0;
        slv.write_enable = 1'b0;
        slv.address      = {ADDR_WIDTH{1'b0}};
        slv.write_data   = {DATA_WIDTH{1'b0}};
        m0.read_data     = {DATA_WIDTH{1'b0}};
        m0.ready         = 1'b0;
        m1.read_data     = {DATA_WIDTH{1'b0}};
        m1.ready         = 1'b0;
        case (grant)
            GRANT_M0: begin
                slv.valid        = m0.valid;
                slv.write_enable = m0.write_enable;
                slv.address      = m0.address;
                slv.write_data   = m0.write_data;
                m0.read_data     = slv.read_data;
                m0.ready         = slv.ready & m0.valid;
            end
            GRANT_M1: begin
                slv.valid        = m1.valid;
                slv.write_enable = m1.write_enable;
                slv.address      = m1.address;
                slv.write_data   = m1.write_data;
                m1.read_data     = slv.read_data;
                m1.ready         = slv.ready & m1.valid;
            end
            default: begin
                slv.valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared memory/IO bus. Master 0 is the CPU port,
// master 1 the auxiliary requester (DMA / debug loader). Ownership is registered,
// a started beat is never interrupted, and a waiting master takes over after
// MAX_BURST completed beats of the current owner.
// Optional feature macro: ARB_ROUND_ROBIN_EN -- when defined, simultaneous requests
// from idle alternate between masters; otherwise master 0 wins every tie.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  m0,
    bus_arbiter_if.slave  m1,
    bus_arbiter_if.master slv,
    output logic [1:0]    grant
);

    localparam int BEAT_WIDTH = $clog2(MAX_BURST + 1);
    // Value held while the MAX_BURST-th beat is on the bus; completing it ends the burst window.
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(MAX_BURST - 1);

    state_t                state;
    state_t                next_state;
    state_t                other_state;
    state_t                tie_winner;
    logic [BEAT_WIDTH-1:0] beat_count;
    logic [BEAT_WIDTH-1:0] next_beat_count;
    logic                  owner_valid;
    logic                  other_valid;
    logic                  beat_done;
    logic                  beat_stalled;

    assign beat_done    = slv.valid & slv.ready;
    assign beat_stalled = slv.valid & ~slv.ready;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last;

    // Remember which master was granted most recently so the next idle tie goes to the other one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (next_state == OWN1) begin
            rr_last <= 1'b1;
        end else if (next_state == OWN0) begin
            rr_last <= 1'b0;
        end
    end

    assign tie_winner = rr_last ? OWN0 : OWN1;
`else
    assign tie_winner = OWN0;
`endif

    // Owner state and beat counter; reset drops ownership at once, which also drops slave valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat_count <= '0;
        end else begin
            state      <= next_state;
            beat_count <= next_beat_count;
        end
    end

    // Decide the next owner: hold through stalled beats, release on dropped valid, rotate at burst limit.
    always_comb begin
        next_state      = state;
        next_beat_count = beat_count;
        owner_valid     = 1'b0;
        other_valid     = 1'b0;
        other_state     = IDLE;
        case (state)
            OWN0: begin
                owner_valid = m0.valid;
                other_valid = m1.valid;
                other_state = OWN1;
            end
            OWN1: begin
                owner_valid = m1.valid;
                other_valid = m0.valid;
                other_state = OWN0;
            end
            default: begin
                owner_valid = 1'b0;
            end
        endcase

        case (state)
            IDLE: begin
                next_beat_count = '0;
                if (m0.valid && m1.valid) begin
                    next_state = tie_winner;
                end else if (m0.valid) begin
                    next_state = OWN0;
                end else if (m1.valid) begin
                    next_state = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!beat_stalled) begin
                    if (!owner_valid) begin
                        next_state      = other_valid ? other_state : IDLE;
                        next_beat_count = '0;
                    end else if (beat_done) begin
                        if (beat_count == LAST_BEAT) begin
                            next_beat_count = '0;
                            if (other_valid) begin
                                next_state = other_state;
                            end
                        end else begin
                            next_beat_count = beat_count + 1'b1;
                        end
                    end
                end
            end
            default: begin
                next_state      = IDLE;
                next_beat_count = '0;
            end
        endcase
    end

    // Grant is a pure decode of the registered owner state.
    always_comb begin
        grant = grant_of(state);
    end

    bus_arbiter_mux #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux (
        .grant(grant),
        .m0   (m0),
        .m1   (m1),
        .slv  (slv)
    );

endmodule
